// File: rtl/blackjack_pkg.sv
// Shared types and constants for the blackjack game sequencer.
// Holds the FSM state codes, the result codes and the hand-scoring helpers.
package blackjack_pkg;

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    DEAL_P1     = 4'd1,
    DEAL_D1     = 4'd2,
    DEAL_P2     = 4'd3,
    DEAL_D2     = 4'd4,
    PLAYER_TURN = 4'd5,
    PLAYER_DRAW = 4'd6,
    DEALER_TURN = 4'd7,
    DEALER_DRAW = 4'd8,
    RESOLVE     = 4'd9,
    DONE        = 4'd10
  } game_state_t;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_WIN  = 2'b01;
  localparam logic [1:0] RES_LOSE = 2'b10;
  localparam logic [1:0] RES_PUSH = 2'b11;

  localparam int BJ_LIMIT     = 21;
  localparam int DEALER_STAND = 17;
  localparam int ACE_BONUS    = 10;

  // One ace may count as 11 when that does not push the hand past the limit.
  function automatic logic [4:0] best_total(input logic [4:0] hard,
                                            input logic       ace,
                                            input int         limit);
    if (ace && (int'(hard) + ACE_BONUS <= limit))
      best_total = 5'(int'(hard) + ACE_BONUS);
    else
      best_total = hard;
  endfunction

  function automatic logic state_draws(input game_state_t st);
    state_draws = (st == DEAL_P1) || (st == DEAL_D1) || (st == DEAL_P2) ||
                  (st == DEAL_D2) || (st == PLAYER_DRAW) || (st == DEALER_DRAW);
  endfunction

endpackage

// File: rtl/blackjack_game_ctrl_hand_accum.sv
// Per-hand accumulator: running hard sum, ace flag, best total, bust flag and
// a saturating card count, all registered.
module hand_accum
  import blackjack_pkg::*;
#(
  parameter int LIMIT = BJ_LIMIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       add,
  input  logic [3:0] value,
  output logic [4:0] hard,
  output logic       ace,
  output logic [4:0] best,
  output logic       bust,
  output logic [3:0] count
);

  logic [4:0] hard_next;
  logic       ace_next;

  always_comb begin
    hard_next = hard + {1'b0, value};
    ace_next  = ace | (value == 4'd1);
  end

  // Derived best/bust are registered alongside the sum so every output is a flop.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      hard  <= 5'd0;
      ace   <= 1'b0;
      best  <= 5'd0;
      bust  <= 1'b0;
      count <= 4'd0;
    end else if (add) begin
      hard <= hard_next;
      ace  <= ace_next;
      best <= best_total(hard_next, ace_next, LIMIT);
      bust <= (int'(hard_next) > LIMIT);
      if (count != 4'd15)
        count <= count + 4'd1;
    end
  end

endmodule

// File: rtl/blackjack_game_ctrl.sv
// Blackjack game sequencer: deals the opening hands, runs the player and
// dealer turns over a req/valid card handshake, and resolves the outcome.
module blackjack_game_ctrl #(
  parameter int DEALER_STAND = 17,
  parameter int BJ_LIMIT     = 21
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       new_game,
  input  logic       hit,
  input  logic       stand,
  output logic       card_req,
  input  logic       card_valid,
  input  logic [3:0] card_value,
  output logic [4:0] player_total,
  output logic [4:0] dealer_total,
  output logic [3:0] player_cards,
  output logic [3:0] dealer_cards,
  output logic [3:0] game_state,
  output logic [1:0] result
);

  import blackjack_pkg::*;

  game_state_t state_q, state_d;
  logic        take;
  logic        p_add, d_add, clear_hands;
  logic [4:0]  p_hard, d_hard;
  logic        p_ace, d_ace, p_bust, d_bust;
  logic [4:0]  p_hard_new, p_best_new;
  logic [1:0]  res_d;
  logic        unused_dealer_bits;

  assign take               = card_req && card_valid;
  assign game_state         = state_q;
  assign unused_dealer_bits = ^{d_hard, d_ace};

  hand_accum #(.LIMIT(BJ_LIMIT)) u_player (
    .clk   (CLOCK_50),
    .reset (reset),
    .clear (clear_hands),
    .add   (p_add),
    .value (card_value),
    .hard  (p_hard),
    .ace   (p_ace),
    .best  (player_total),
    .bust  (p_bust),
    .count (player_cards)
  );

  hand_accum #(.LIMIT(BJ_LIMIT)) u_dealer (
    .clk   (CLOCK_50),
    .reset (reset),
    .clear (clear_hands),
    .add   (d_add),
    .value (card_value),
    .hard  (d_hard),
    .ace   (d_ace),
    .best  (dealer_total),
    .bust  (d_bust),
    .count (dealer_cards)
  );

  // The player-draw decision must see the hand including the card being taken.
  always_comb begin
    p_hard_new = p_hard + {1'b0, card_value};
    p_best_new = best_total(p_hard_new, p_ace | (card_value == 4'd1), BJ_LIMIT);
  end

  always_comb begin
    res_d = RES_PUSH;
    if (p_bust)
      res_d = RES_LOSE;
    else if (d_bust)
      res_d = RES_WIN;
    else if (player_total > dealer_total)
      res_d = RES_WIN;
    else if (player_total < dealer_total)
      res_d = RES_LOSE;
  end

  always_comb begin
    state_d     = state_q;
    p_add       = 1'b0;
    d_add       = 1'b0;
    clear_hands = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (new_game) begin
          clear_hands = 1'b1;
          state_d     = DEAL_P1;
        end
      end
      DEAL_P1: if (take) begin p_add = 1'b1; state_d = DEAL_D1; end
      DEAL_D1: if (take) begin d_add = 1'b1; state_d = DEAL_P2; end
      DEAL_P2: if (take) begin p_add = 1'b1; state_d = DEAL_D2; end
      DEAL_D2: if (take) begin d_add = 1'b1; state_d = PLAYER_TURN; end
      // A natural 21 stands on its own; stand outranks a simultaneous hit.
      PLAYER_TURN: begin
        if (int'(player_total) == BJ_LIMIT || stand)
          state_d = DEALER_TURN;
        else if (hit)
          state_d = PLAYER_DRAW;
      end
      PLAYER_DRAW: begin
        if (take) begin
          p_add = 1'b1;
          if (int'(p_hard_new) > BJ_LIMIT)
            state_d = RESOLVE;
          else if (int'(p_best_new) == BJ_LIMIT)
            state_d = DEALER_TURN;
          else
            state_d = PLAYER_TURN;
        end
      end
      DEALER_TURN: begin
        if (int'(dealer_total) >= DEALER_STAND)
          state_d = RESOLVE;
        else
          state_d = DEALER_DRAW;
      end
      DEALER_DRAW: if (take) begin d_add = 1'b1; state_d = DEALER_TURN; end
      RESOLVE:     state_d = DONE;
      default:     state_d = IDLE;
    endcase
  end

  // card_req is registered from the next state so it lines up with the draw states.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= IDLE;
      card_req <= 1'b0;
      result   <= RES_NONE;
    end else begin
      state_q  <= state_d;
      card_req <= state_draws(state_d);
      if (state_q == RESOLVE)
        result <= res_d;
      else if (state_d != DONE)
        result <= RES_NONE;
    end
  end

endmodule

// File: tb/tb_blackjack_game_ctrl.sv
// Self-checking bench for blackjack_game_ctrl: directed scenarios plus random
// games scored by a card-list reference model of the blackjack rules.
module tb_blackjack_game_ctrl;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       new_game = 1'b0;
  logic       hit = 1'b0;
  logic       stand = 1'b0;
  logic       card_valid = 1'b0;
  logic [3:0] card_value = 4'd0;
  logic       card_req;
  logic [4:0] player_total, dealer_total;
  logic [3:0] player_cards, dealer_cards, game_state;
  logic [1:0] result;

  int deck [40];
  int deck_idx = 0;
  int valid_mode = 1;
  int total_cnt = 0;
  int bad_cnt = 0;

  localparam int S_IDLE = 0, S_DEAL_D1 = 2, S_PTURN = 5, S_PDRAW = 6, S_DTURN = 7, S_DONE = 10;

  blackjack_game_ctrl dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .new_game     (new_game),
    .hit          (hit),
    .stand        (stand),
    .card_req     (card_req),
    .card_valid   (card_valid),
    .card_value   (card_value),
    .player_total (player_total),
    .dealer_total (dealer_total),
    .player_cards (player_cards),
    .dealer_cards (dealer_cards),
    .game_state   (game_state),
    .result       (result)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // One clock cycle: drive keys and the card source, then sample 1 ns after the edge.
  task automatic applyStimulus(input logic ng, input logic h, input logic s);
    logic accept;
    new_game   = ng;
    hit        = h;
    stand      = s;
    card_value = 4'(deck[deck_idx]);
    case (valid_mode)
      0:       card_valid = ($urandom_range(0, 2) != 0);
      1:       card_valid = 1'b1;
      default: card_valid = 1'b0;
    endcase
    accept = card_req && card_valid && !reset;
    @(posedge CLOCK_50);
    #1;
    if (accept && deck_idx < 39) deck_idx++;
    new_game = 1'b0;
    hit      = 1'b0;
    stand    = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) else begin
      bad_cnt++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic waitState(input string tag, input int code, input int budget);
    int n = 0;
    while (int'(game_state) != code && n < budget) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      n++;
    end
    checkOutput(tag, 16'(game_state), 16'(code));
  endtask

  task automatic setDeck(input int a, input int b, input int c, input int d,
                         input int e, input int f);
    for (int i = 0; i < 40; i++) deck[i] = 10;
    deck[0] = a; deck[1] = b; deck[2] = c; deck[3] = d; deck[4] = e; deck[5] = f;
    deck_idx = 0;
  endtask

  function automatic int hardOf(input int cards [40], input int n);
    int sum = 0;
    for (int i = 0; i < n; i++) sum += cards[i];
    return sum;
  endfunction

  function automatic int bestOf(input int cards [40], input int n);
    int  sum = 0;
    bit  has_ace = 0;
    for (int i = 0; i < n; i++) begin
      sum += cards[i];
      if (cards[i] == 1) has_ace = 1;
    end
    if (has_ace && sum + 10 <= 21) return sum + 10;
    return sum;
  endfunction

  initial begin : main
    int ph [40];
    int dh [40];
    int pn, dn, nxt, thr, pb, db, exp_res, cyc;

    // Reset values
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    checkOutput("rst_state", 16'(game_state), 16'(S_IDLE));
    checkOutput("rst_req", 16'(card_req), 16'd0);
    checkOutput("rst_ptot", 16'(player_total), 16'd0);
    checkOutput("rst_dtot", 16'(dealer_total), 16'd0);
    checkOutput("rst_pcnt", 16'(player_cards), 16'd0);
    checkOutput("rst_result", 16'(result), 16'd0);

    // Natural 21 auto-stands; dealer 16 draws a 5 to push
    setDeck(10, 6, 1, 10, 5, 10);
    valid_mode = 1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("deal_req", 16'(card_req), 16'd1);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("deal4_state", 16'(game_state), 16'(S_PTURN));
    checkOutput("deal4_ptot", 16'(player_total), 16'd21);
    checkOutput("deal4_result", 16'(result), 16'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("auto_stand", 16'(game_state), 16'(S_DTURN));
    waitState("push_done", S_DONE, 20);
    checkOutput("push_result", 16'(result), 16'd3);
    checkOutput("push_ptot", 16'(player_total), 16'd21);
    checkOutput("push_dtot", 16'(dealer_total), 16'd21);
    checkOutput("push_dcnt", 16'(dealer_cards), 16'd3);

    // Player busts on a hit; dealer never draws
    setDeck(10, 10, 6, 7, 9, 10);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitState("bust_pturn", S_PTURN, 20);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("hit_state", 16'(game_state), 16'(S_PDRAW));
    checkOutput("hit_req", 16'(card_req), 16'd1);
    waitState("bust_done", S_DONE, 20);
    checkOutput("bust_result", 16'(result), 16'd2);
    checkOutput("bust_dcnt", 16'(dealer_cards), 16'd2);
    checkOutput("bust_ptot", 16'(player_total), 16'd25);
    checkOutput("bust_pcnt", 16'(player_cards), 16'd3);

    // Dealer soft 17 stands
    setDeck(9, 1, 8, 6, 10, 10);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitState("soft_pturn", S_PTURN, 20);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("stand_state", 16'(game_state), 16'(S_DTURN));
    waitState("soft_done", S_DONE, 20);
    checkOutput("soft_dcnt", 16'(dealer_cards), 16'd2);
    checkOutput("soft_dtot", 16'(dealer_total), 16'd17);
    checkOutput("soft_result", 16'(result), 16'd3);

    // Handshake stall in DEAL_D1, then hit+stand together, then ignored hit
    setDeck(5, 4, 3, 2, 10, 10);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    valid_mode = 2;
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("stall_state", 16'(game_state), 16'(S_DEAL_D1));
    checkOutput("stall_req", 16'(card_req), 16'd1);
    checkOutput("stall_pcnt", 16'(player_cards), 16'd1);
    checkOutput("stall_dcnt", 16'(dealer_cards), 16'd0);
    valid_mode = 1;
    waitState("stall_pturn", S_PTURN, 20);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("hs_state", 16'(game_state), 16'(S_DTURN));
    checkOutput("hs_pcnt", 16'(player_cards), 16'd2);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitState("hs_done", S_DONE, 20);
    checkOutput("hs_pcnt_end", 16'(player_cards), 16'd2);
    checkOutput("hs_dtot", 16'(dealer_total), 16'd26);
    checkOutput("hs_result", 16'(result), 16'd1);

    // Reset mid-hand while a card is offered
    setDeck(2, 3, 4, 5, 6, 10);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitState("mid_pturn", S_PTURN, 20);
    applyStimulus(1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    checkOutput("mid_state", 16'(game_state), 16'(S_IDLE));
    checkOutput("mid_req", 16'(card_req), 16'd0);
    checkOutput("mid_ptot", 16'(player_total), 16'd0);
    checkOutput("mid_pcnt", 16'(player_cards), 16'd0);
    checkOutput("mid_dtot", 16'(dealer_total), 16'd0);
    checkOutput("mid_deck", 16'(deck_idx), 16'd4);

    // Random games against the rules model
    for (int g = 0; g < 40; g++) begin
      for (int i = 0; i < 40; i++) deck[i] = $urandom_range(1, 10);
      deck_idx   = 0;
      valid_mode = 0;
      thr        = $urandom_range(12, 20);
      ph[0] = deck[0]; dh[0] = deck[1]; ph[1] = deck[2]; dh[1] = deck[3];
      pn = 2; dn = 2; nxt = 4;
      applyStimulus(1'b1, 1'b0, 1'b0);
      cyc = 0;
      while (int'(game_state) != S_DONE && cyc < 500) begin
        if (int'(game_state) == S_PTURN && bestOf(ph, pn) != 21) begin
          if (bestOf(ph, pn) < thr) begin
            ph[pn] = deck[nxt]; pn++; nxt++;
            applyStimulus(1'b0, 1'b1, 1'b0);
          end else begin
            applyStimulus(1'b0, 1'b0, 1'b1);
          end
        end else begin
          applyStimulus(1'b0, 1'b0, 1'b0);
        end
        cyc++;
      end
      checkOutput("rnd_done", 16'(game_state), 16'(S_DONE));
      if (hardOf(ph, pn) <= 21)
        while (bestOf(dh, dn) < 17) begin
          dh[dn] = deck[nxt]; dn++; nxt++;
        end
      pb = bestOf(ph, pn);
      db = bestOf(dh, dn);
      if (hardOf(ph, pn) > 21)      exp_res = 2;
      else if (hardOf(dh, dn) > 21) exp_res = 1;
      else if (pb > db)             exp_res = 1;
      else if (pb < db)             exp_res = 2;
      else                          exp_res = 3;
      checkOutput("rnd_ptot", 16'(player_total), 16'(pb));
      checkOutput("rnd_dtot", 16'(dealer_total), 16'(db));
      checkOutput("rnd_pcnt", 16'(player_cards), 16'(pn));
      checkOutput("rnd_dcnt", 16'(dealer_cards), 16'(dn));
      checkOutput("rnd_result", 16'(result), 16'(exp_res));
      checkOutput("rnd_consumed", 16'(deck_idx), 16'(nxt));
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/blackjack_game_ctrl.md
# blackjack_game_ctrl

Game sequencer for the FPGA blackjack design. Deals the opening hands, accepts debounced hit/stand pulses during the player's turn, and draws dealer cards until 17. It then resolves win/lose/push. Sits between the key edge-detect logic and the card source (deck/RNG), and feeds totals and result to the HEX display encoders inside `blackjack_top`.

## Interface
Parameters:
- `DEALER_STAND`, 17: dealer stands when best total ≥ this; soft 17 stands.
- `BJ_LIMIT`, 21: bust threshold.

Ports:
- `CLOCK_50`  in  1  system clock; one clock domain; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `new_game`  in  1  single-cycle pulse; starts a deal from IDLE or DONE.
- `hit`  in  1  single-cycle pulse; player draws.
- `stand`  in  1  single-cycle pulse; player ends turn.
- `card_req`  out  1  request one card from the card source.
- `card_valid`  in  1  card present on `card_value`; consumed when `card_req` is also high.
- `card_value`  in  4  card value 1..10; ace = 1.
- `player_total`  out  5  player best total.
- `dealer_total`  out  5  dealer best total.
- `player_cards`  out  4  player card count.
- `dealer_cards`  out  4  dealer card count.
- `game_state`  out  4  current FSM state code.
- `result`  out  2  00 none, 01 win, 10 lose, 11 push.

## Operation
- States: IDLE → DEAL_P1 → DEAL_D1 → DEAL_P2 → DEAL_D2 → PLAYER_TURN ⇄ PLAYER_DRAW → DEALER_TURN ⇄ DEALER_DRAW → RESOLVE → DONE.
- Reset: state IDLE. All totals and counts 0, `result` 00, `card_req` 0. Reset mid-hand abandons the hand immediately; a card presented in the same cycle is dropped.
- `new_game` in IDLE or DONE clears both hands and `result`, then enters DEAL_P1. Ignored in all other states.
- Card handshake:
  - `card_req` is high in every DEAL_* and *_DRAW state.
  - A card is taken on the first edge where `card_req` and `card_valid` are both high.
  - The state advances on that same edge, so `card_req` drops the next cycle unless the next state also draws.
  - `card_valid` is ignored while `card_req` is low.
  - There is no timeout; the controller waits indefinitely.
- Hand arithmetic, per hand:
  - `hard` is the 5-bit sum with aces counted as 1. Maximum reachable is 30, so there is no overflow.
  - `ace` flag is set when any ace has been drawn.
  - `best` = hard+10 if ace and hard+10 ≤ 21, else hard.
  - bust = hard > 21.
  - Card count saturates at 15.
- PLAYER_TURN:
  - `stand` → DEALER_TURN. If `hit` and `stand` arrive in the same cycle, stand wins.
  - `hit` → PLAYER_DRAW.
  - Entry with best = 21 (including the opening two cards) → DEALER_TURN on the next edge, no key needed.
  - Pulses are ignored in every other state.
- PLAYER_DRAW: on card accept, go to RESOLVE if the new hard > 21, DEALER_TURN if the new best = 21, else PLAYER_TURN.
- DEALER_TURN: one decision cycle; best ≥ DEALER_STAND → RESOLVE, else DEALER_DRAW. DEALER_DRAW always returns to DEALER_TURN.
- RESOLVE decides `result`, checked in this order:
  - player bust → lose;
  - dealer bust → win;
  - player best > dealer best → win;
  - player best < dealer best → lose;
  - equal → push.
- RESOLVE then goes to DONE. `result` and totals hold in DONE until `new_game` or `reset`.

## Timing
- All outputs are registered.
- Totals and counts update on the edge that accepts the card, so they are visible the following cycle.
- With `card_valid` tied high, an uninterrupted deal takes 4 cycles and PLAYER_TURN is reached 4 cycles after the `new_game` edge.
- Hit response: `card_req` rises 1 cycle after the `hit` edge.
- Each dealer draw costs 2 cycles minimum (TURN + DRAW).
- `result` is valid the cycle after RESOLVE, i.e. on DONE entry; it stays 00 in every state other than DONE.

## Structure
- `blackjack_pkg` holds:
  - the state enum and its 4-bit codes (IDLE=0 … DONE=10);
  - result codes RES_NONE/WIN/LOSE/PUSH;
  - constants BJ_LIMIT=21, DEALER_STAND=17, ACE_BONUS=10.
- One sub-module, `hand_accum`, instantiated twice (player, dealer):
  - inputs: clk, reset, clear, add, value[3:0];
  - outputs: hard, ace, best, bust, count.
- The FSM lives in `blackjack_game_ctrl`.

## Test plan
- Reset mid-hand: assert `reset` in PLAYER_DRAW with `card_valid`=1 → next cycle state IDLE, all totals 0, `card_req`=0, card not counted.
- Deal 10,6,A,10 then `stand`: player=A+10 → best 21, auto-stands without a key. Dealer 16 → draws 5 → 21. Expect `result`=11 (push), player_total=21, dealer_total=21.
- Deal 10,10,6,7 then `hit` with card 9: player hard 25 → RESOLVE, dealer never draws. Expect `result`=10, dealer_cards=2.
- Soft 17: deal 9,A,8,6 then `stand`. Dealer A+6 = best 17 → stands with no dealer draw. Player 17 → `result`=11.
- Handshake stall: hold `card_valid`=0 for 5 cycles in DEAL_D1 → `card_req` stays 1, state unchanged, counts unchanged. Release → proceeds.
- Simultaneous `hit`+`stand` in PLAYER_TURN → DEALER_TURN, no player card drawn. A `hit` pulse in DEALER_TURN is ignored and player_cards is unchanged.
